// File: rtl/d_cache_ctrl_pkg.sv
// rtl/d_cache_ctrl_pkg.sv - shared widths, FSM encodings and address field helpers for the data cache
package d_cache_ctrl_pkg;

    localparam int ADDR_W     = 12;
    localparam int OFFSET_W   = 2;
    localparam int INDEX_W    = 3;
    localparam int TAG_W      = 7;
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_REFILL  = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    typedef struct packed {
        logic              wen;
        logic [3:0]        be;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       di;
    } req_t;

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W+INDEX_W-1:OFFSET_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:OFFSET_W+INDEX_W];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/data storage: combinational read, byte-enabled write, invalidate-all
module dcache_array
    import d_cache_ctrl_pkg::*;
(
    input  logic                CLK,
    input  logic                inval_all,
    input  logic [INDEX_W-1:0]  index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    output logic [31:0]         rd_data,
    input  logic                wr_en,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [3:0]          wr_be,
    input  logic [31:0]         wr_data,
    input  logic                tag_we,
    input  logic [TAG_W-1:0]    tag_in,
    input  logic                clr_valid
);

    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];
    assign rd_data  = data_q[index][rd_offset];

    always_ff @(posedge CLK) begin
        if (inval_all) begin
            valid_q <= '0;
        end else if (clr_valid) begin
            valid_q[index] <= 1'b0;
        end else if (tag_we) begin
            valid_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (tag_we) begin
            tag_q[index] <= tag_in;
        end
    end

    always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b]) begin
                data_q[index][wr_offset][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/d_cache_ctrl.sv
// rtl/d_cache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
module d_cache_ctrl
    import d_cache_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Cache_CSN,
    input  logic              Cache_WEN,
    input  logic [3:0]        Cache_BE,
    input  logic [ADDR_W-1:0] Cache_ADDR,
    input  logic [31:0]       Cache_DI,
    output logic [31:0]       Cache_DOUT,
    output logic              RDY,
    output logic              VALID,
    output logic              D_MEM_CSN,
    output logic              D_MEM_WEN,
    output logic [3:0]        D_MEM_BE,
    output logic [ADDR_W-1:0] D_MEM_ADDR,
    output logic [31:0]       D_MEM_DOUT,
    input  logic [31:0]       D_MEM_DI,
    output logic [31:0]       HIT_CNT,
    output logic [31:0]       MISS_CNT
);

    logic [1:0]       state_q;
    logic [2:0]       cnt_q;
    req_t             req_q;
    logic [31:0]      hit_q;
    logic [31:0]      miss_q;

    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic [31:0]      rd_data;
    logic             hit;
    logic             in_compare;
    logic             is_write;
    logic             refill_issue;
    logic             refill_capture;
    logic             tag_we;
    logic             clr_valid;
    logic [1:0]       cap_offset;

    assign hit        = rd_valid && (rd_tag == addr_tag(req_q.addr));
    assign in_compare = RSTn && (state_q == S_COMPARE);
    assign is_write   = in_compare && !req_q.wen;
    assign clr_valid  = in_compare && req_q.wen && !hit;

    // cnt_q runs 0..4: issue reads while cnt<4, capture word cnt-1 while cnt>0
    assign refill_issue   = RSTn && (state_q == S_REFILL) && (cnt_q != 3'd4);
    assign refill_capture = RSTn && (state_q == S_REFILL) && (cnt_q != 3'd0);
    assign tag_we         = RSTn && (state_q == S_REFILL) && (cnt_q == 3'd4);
    assign cap_offset     = cnt_q[1:0] - 2'd1;

    dcache_array u_array (
        .CLK       (CLK),
        .inval_all (!RSTn),
        .index     (addr_index(req_q.addr)),
        .rd_offset (addr_offset(req_q.addr)),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_en     (refill_capture || (is_write && hit)),
        .wr_offset (refill_capture ? cap_offset : addr_offset(req_q.addr)),
        .wr_be     (refill_capture ? 4'hF : req_q.be),
        .wr_data   (refill_capture ? D_MEM_DI : req_q.di),
        .tag_we    (tag_we),
        .tag_in    (addr_tag(req_q.addr)),
        .clr_valid (clr_valid)
    );

    assign RDY        = RSTn && (state_q == S_IDLE);
    assign VALID      = RSTn && (((state_q == S_COMPARE) && (!req_q.wen || hit)) || (state_q == S_RESPOND));
    assign Cache_DOUT = (VALID && req_q.wen) ? rd_data : '0;
    assign D_MEM_CSN  = !(is_write || refill_issue);
    assign D_MEM_WEN  = !is_write;
    assign D_MEM_BE   = is_write ? req_q.be : 4'h0;
    assign D_MEM_ADDR = is_write     ? req_q.addr :
                        refill_issue ? {req_q.addr[ADDR_W-1:OFFSET_W], cnt_q[1:0]} : '0;
    assign D_MEM_DOUT = is_write ? req_q.di : '0;
    assign HIT_CNT    = hit_q;
    assign MISS_CNT   = miss_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!Cache_CSN) begin
                        req_q   <= '{wen: Cache_WEN, be: Cache_BE, addr: Cache_ADDR, di: Cache_DI};
                        state_q <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        hit_q <= hit_q + 32'd1;
                    end else begin
                        miss_q <= miss_q + 32'd1;
                    end
                    if (!req_q.wen || hit) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_REFILL;
                        cnt_q   <= '0;
                    end
                end
                S_REFILL: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd4) begin
                        state_q <= S_RESPOND;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// tb/tb_d_cache_ctrl.sv - self-checking bench for d_cache_ctrl with a synchronous memory model
module tb_d_cache_ctrl;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Cache_CSN = 1'b1;
    logic        Cache_WEN = 1'b1;
    logic [3:0]  Cache_BE = 4'h0;
    logic [11:0] Cache_ADDR = 12'h0;
    logic [31:0] Cache_DI = 32'h0;
    logic [31:0] Cache_DOUT;
    logic        RDY;
    logic        VALID;
    logic        D_MEM_CSN;
    logic        D_MEM_WEN;
    logic [3:0]  D_MEM_BE;
    logic [11:0] D_MEM_ADDR;
    logic [31:0] D_MEM_DOUT;
    logic [31:0] D_MEM_DI;
    logic [31:0] HIT_CNT;
    logic [31:0] MISS_CNT;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] di;
        int          lat;
        logic [31:0] dout;
        int          nrd;
        int          nwr;
        logic [31:0] hits;
        logic [31:0] misses;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] sb_q[$];

    logic [31:0]   mem [4096];
    logic [4095:0] written = '0;
    logic [31:0]   mem_rdata = 32'h0;

    d_cache_ctrl dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .Cache_CSN  (Cache_CSN),
        .Cache_WEN  (Cache_WEN),
        .Cache_BE   (Cache_BE),
        .Cache_ADDR (Cache_ADDR),
        .Cache_DI   (Cache_DI),
        .Cache_DOUT (Cache_DOUT),
        .RDY        (RDY),
        .VALID      (VALID),
        .D_MEM_CSN  (D_MEM_CSN),
        .D_MEM_WEN  (D_MEM_WEN),
        .D_MEM_BE   (D_MEM_BE),
        .D_MEM_ADDR (D_MEM_ADDR),
        .D_MEM_DOUT (D_MEM_DOUT),
        .D_MEM_DI   (D_MEM_DI),
        .HIT_CNT    (HIT_CNT),
        .MISS_CNT   (MISS_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input logic [11:0] a);
        case (a)
            12'h010: return 32'h0000_0011;
            12'h011: return 32'h0000_0022;
            12'h012: return 32'h0000_0033;
            12'h013: return 32'h0000_0044;
            default: return {20'hC0DE0, a};
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return written[a] ? mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge CLK) begin
        if (!D_MEM_CSN) begin
            if (D_MEM_WEN) begin
                mem_rdata <= mem_word(D_MEM_ADDR);
            end else begin
                mem[D_MEM_ADDR]     <= merge(mem_word(D_MEM_ADDR), D_MEM_DOUT, D_MEM_BE);
                written[D_MEM_ADDR] <= 1'b1;
            end
        end
    end
    assign D_MEM_DI = mem_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v);
        int   nrd;
        int   nwr;
        int   lat;
        logic done;
        logic [31:0] exp_dout;
        @(negedge CLK);
        Cache_CSN  = 1'b0;
        Cache_WEN  = v.wen;
        Cache_BE   = v.be;
        Cache_ADDR = v.addr;
        Cache_DI   = v.di;
        if (v.wen) sb_q.push_back(v.dout);
        nrd = 0;
        nwr = 0;
        lat = 0;
        done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge CLK);
            if (!D_MEM_CSN) begin
                if (D_MEM_WEN) begin
                    check("refill_addr", {20'h0, D_MEM_ADDR}, {20'h0, v.addr[11:2], 2'(nrd)});
                    check("refill_cycle", 32'(c), 32'(nrd + 2));
                    nrd++;
                end else begin
                    check("wr_addr", {20'h0, D_MEM_ADDR}, {20'h0, v.addr});
                    check("wr_be", {28'h0, D_MEM_BE}, {28'h0, v.be});
                    check("wr_data", D_MEM_DOUT, v.di);
                    check("wr_cycle", 32'(c), 32'd1);
                    nwr++;
                end
            end
            if (VALID) begin
                lat = c;
                done = 1'b1;
                if (v.wen) begin
                    exp_dout = sb_q.pop_front();
                    check("read_data", Cache_DOUT, exp_dout);
                end
            end
        end
        Cache_CSN = 1'b1;
        if (!done) begin
            failures++;
            $display("FAIL valid_timeout addr=0x%03h", v.addr);
            if (v.wen) void'(sb_q.pop_front());
        end
        check("latency", 32'(lat), 32'(v.lat));
        check("mem_reads", 32'(nrd), 32'(v.nrd));
        check("mem_writes", 32'(nwr), 32'(v.nwr));
        @(negedge CLK);
        check("rdy_after", {31'h0, RDY}, 32'd1);
        check("hit_cnt", HIT_CNT, v.hits);
        check("miss_cnt", MISS_CNT, v.misses);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{1'b1, 4'h0, 12'h010, 32'h0,          7, 32'h0000_0011, 4, 0, 32'd0, 32'd1};
        vecs[1] = '{1'b1, 4'h0, 12'h012, 32'h0,          1, 32'h0000_0033, 0, 0, 32'd1, 32'd1};
        vecs[2] = '{1'b0, 4'h3, 12'h011, 32'hAABB_CCDD,  1, 32'h0,         0, 1, 32'd2, 32'd1};
        vecs[3] = '{1'b1, 4'h0, 12'h011, 32'h0,          1, 32'h0000_CCDD, 0, 0, 32'd3, 32'd1};
        vecs[4] = '{1'b1, 4'h0, 12'h090, 32'h0,          7, 32'hC0DE_0090, 4, 0, 32'd3, 32'd2};
        vecs[5] = '{1'b1, 4'h0, 12'h010, 32'h0,          7, 32'h0000_0011, 4, 0, 32'd3, 32'd3};
        vecs[6] = '{1'b1, 4'h0, 12'h013, 32'h0,          1, 32'h0000_0044, 0, 0, 32'd4, 32'd3};
        vecs[7] = '{1'b0, 4'hF, 12'h1F0, 32'h1234_5678,  1, 32'h0,         0, 1, 32'd4, 32'd4};
        vecs[8] = '{1'b1, 4'h0, 12'h1F0, 32'h0,          7, 32'h1234_5678, 4, 0, 32'd4, 32'd5};
        vecs[9] = '{1'b1, 4'h0, 12'h1F0, 32'h0,          1, 32'h1234_5678, 0, 0, 32'd5, 32'd5};

        repeat (3) @(negedge CLK);
        check("rst_rdy", {31'h0, RDY}, 32'd0);
        check("rst_valid", {31'h0, VALID}, 32'd0);
        check("rst_mem_csn", {31'h0, D_MEM_CSN}, 32'd1);
        check("rst_mem_wen", {31'h0, D_MEM_WEN}, 32'd1);
        check("rst_mem_be", {28'h0, D_MEM_BE}, 32'd0);
        check("rst_mem_addr", {20'h0, D_MEM_ADDR}, 32'd0);
        check("rst_mem_dout", D_MEM_DOUT, 32'd0);
        check("rst_dout", Cache_DOUT, 32'd0);
        check("rst_hit", HIT_CNT, 32'd0);
        check("rst_miss", MISS_CNT, 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);
        check("idle_rdy", {31'h0, RDY}, 32'd1);
        repeat (3) begin
            @(negedge CLK);
            check("idle_mem_csn", {31'h0, D_MEM_CSN}, 32'd1);
            check("idle_valid", {31'h0, VALID}, 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i]);
        end

        // Reset arrives during the second refill cycle of a read miss
        @(negedge CLK);
        Cache_CSN  = 1'b0;
        Cache_WEN  = 1'b1;
        Cache_ADDR = 12'h0A0;
        @(negedge CLK);
        @(negedge CLK);
        check("mr_issue0_csn", {31'h0, D_MEM_CSN}, 32'd0);
        check("mr_issue0_addr", {20'h0, D_MEM_ADDR}, 32'h0A0);
        @(negedge CLK);
        check("mr_issue1_addr", {20'h0, D_MEM_ADDR}, 32'h0A1);
        RSTn = 1'b0;
        Cache_CSN = 1'b1;
        @(negedge CLK);
        check("mr_mem_idle", {31'h0, D_MEM_CSN}, 32'd1);
        check("mr_valid", {31'h0, VALID}, 32'd0);
        check("mr_rdy", {31'h0, RDY}, 32'd0);
        repeat (2) begin
            @(negedge CLK);
            check("mr_valid_hold", {31'h0, VALID}, 32'd0);
            check("mr_mem_idle_hold", {31'h0, D_MEM_CSN}, 32'd1);
        end
        RSTn = 1'b1;
        @(negedge CLK);
        check("mr_rdy_release", {31'h0, RDY}, 32'd1);
        check("mr_hit_clr", HIT_CNT, 32'd0);
        check("mr_miss_clr", MISS_CNT, 32'd0);
        v = '{1'b1, 4'h0, 12'h010, 32'h0, 7, 32'h0000_0011, 4, 0, 32'd0, 32'd1};
        do_req(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
